// File: rtl/seq_div8x4.sv
// seq_div8x4 -- sequential 8-bit by 4-bit unsigned restoring divider.
// Resolves one quotient bit per clock (MSB first) under a Start/Done handshake.
// A divide by zero completes one cycle after accept with Q=8'hFF, R=N[3:0].
//
// Ports:
//   Clk      in   clock, rising edge
//   Reset_b  in   synchronous active-low reset
//   Start    in   request, sampled in IDLE or DONE
//   N        in   8-bit dividend, captured on accept
//   D        in   4-bit divisor, captured on accept
//   Q        out  8-bit quotient (registered, held until next completion)
//   R        out  4-bit remainder (registered, held until next completion)
//   Busy     out  high while the iteration loop runs
//   Done     out  one-cycle completion pulse; Q/R/DivZero valid from here on
//   DivZero  out  set on completion when the captured divisor was zero
module seq_div8x4 (
   input  logic       Clk,
   input  logic       Reset_b,
   input  logic       Start,
   input  logic [7:0] N,
   input  logic [3:0] D,
   output logic [7:0] Q,
   output logic [3:0] R,
   output logic       Busy,
   output logic       Done,
   output logic       DivZero
);

   localparam int unsigned NW = 8;        // dividend / quotient width
   localparam int unsigned DW = 4;        // divisor / remainder width
   localparam int unsigned PW = DW + 1;   // shifted partial remainder width
   localparam int unsigned CW = 3;        // iteration counter width

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [NW-1:0]   nsh_q, nsh_d;       // dividend shifter
   logic [DW-1:0]   dv_q, dv_d;         // captured divisor
   logic [DW-1:0]   p_q, p_d;           // partial remainder (always < divisor)
   logic [NW-1:0]   qsh_q, qsh_d;       // quotient shifter
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NW-1:0]   q_q, q_d;
   logic [DW-1:0]   r_q, r_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            dz_q, dz_d;

   // One restoring step. The stored remainder stays below the divisor, so
   // only the shifted value needs the extra bit ahead of the compare.
   logic [PW-1:0]   p_shift;
   logic            qbit;
   logic [DW-1:0]   p_rem;
   logic [NW-1:0]   qsh_step;

   always_comb begin
      p_shift  = {p_q, nsh_q[NW-1]};
      qbit     = (p_shift >= PW'(dv_q));
      p_rem    = qbit ? DW'(p_shift - PW'(dv_q)) : p_shift[DW-1:0];
      qsh_step = {qsh_q[NW-2:0], qbit};
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      nsh_d   = nsh_q;
      dv_d    = dv_q;
      p_d     = p_q;
      qsh_d   = qsh_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (Start) begin
               if (D != '0) begin
                  state_d = S_RUN;
                  nsh_d   = N;
                  dv_d    = D;
                  p_d     = '0;
                  qsh_d   = '0;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
               end else begin
                  state_d = S_DONE;
                  q_d     = '1;
                  r_d     = N[DW-1:0];
                  dz_d    = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end
         S_RUN: begin
            nsh_d = {nsh_q[NW-2:0], 1'b0};
            p_d   = p_rem;
            qsh_d = qsh_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NW - 1)) begin
               // Result written on the last iteration so it lines up with Done.
               state_d = S_DONE;
               q_d     = qsh_step;
               r_d     = p_rem;
               dz_d    = 1'b0;
               done_d  = 1'b1;
            end else begin
               busy_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge Clk) begin
      if (!Reset_b) begin
         state_q <= S_IDLE;
         nsh_q   <= '0;
         dv_q    <= '0;
         p_q     <= '0;
         qsh_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         nsh_q   <= nsh_d;
         dv_q    <= dv_d;
         p_q     <= p_d;
         qsh_q   <= qsh_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign Q       = q_q;
   assign R       = r_q;
   assign Busy    = busy_q;
   assign Done    = done_q;
   assign DivZero = dz_q;

endmodule
